// File: rtl/pp_hazard_ctrl_if.sv
// Hazard request / pipeline control bundle between the
// pipeline stages and the central hazard controller.
interface pp_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ddep_conflict_i;
    logic             ex_busy_i;
    logic             mem_wait_i;
    logic             branch_taken_i;
    logic             exc_i;
    logic             cnt_clr_i;
    logic             stall_if_o;
    logic             stall_dec_o;
    logic             stall_ex_o;
    logic             stall_mem_o;
    logic             bubble_ex_o;
    logic             bubble_mem_o;
    logic             bubble_wb_o;
    logic             flush_if_o;
    logic             flush_dec_o;
    logic             flush_ex_o;
    logic             init_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output ddep_conflict_i, ex_busy_i, mem_wait_i,
        output branch_taken_i, exc_i, cnt_clr_i,
        input  stall_if_o, stall_dec_o, stall_ex_o,
        input  stall_mem_o, bubble_ex_o, bubble_mem_o,
        input  bubble_wb_o, flush_if_o, flush_dec_o,
        input  flush_ex_o, init_o, stall_cnt_o
    );

    modport slave (
        input  ddep_conflict_i, ex_busy_i, mem_wait_i,
        input  branch_taken_i, exc_i, cnt_clr_i,
        output stall_if_o, stall_dec_o, stall_ex_o,
        output stall_mem_o, bubble_ex_o, bubble_mem_o,
        output bubble_wb_o, flush_if_o, flush_dec_o,
        output flush_ex_o, init_o, stall_cnt_o
    );
endinterface

// File: rtl/pp_hazard_ctrl.sv
// Central stall/flush/bubble controller for the 5-stage
// pipeline, with held redirects and a stall-cycle counter.
module pp_hazard_ctrl #(
    parameter int INIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input logic             clk,
    input logic             rst_n,
    pp_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       init_cnt_q, init_cnt_d;
    logic [1:0]       pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q;
    logic             blk, m_exc, m_br;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        blk   = hz.mem_wait_i | hz.ex_busy_i;
        // pend_q = {exc, br}; an exception always supersedes a branch
        m_exc = pend_q[1] | hz.exc_i;
        m_br  = ~m_exc & (pend_q[0] | hz.branch_taken_i);

        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        pend_d          = pend_q;
        hz.stall_if_o   = 1'b0;
        hz.stall_dec_o  = 1'b0;
        hz.stall_ex_o   = 1'b0;
        hz.stall_mem_o  = 1'b0;
        hz.bubble_ex_o  = 1'b0;
        hz.bubble_mem_o = 1'b0;
        hz.bubble_wb_o  = 1'b0;
        hz.flush_if_o   = 1'b0;
        hz.flush_dec_o  = 1'b0;
        hz.flush_ex_o   = 1'b0;
        hz.init_o       = 1'b0;

        unique case (state_q)
            S_INIT: begin
                hz.init_o      = 1'b1;
                hz.flush_if_o  = 1'b1;
                hz.flush_dec_o = 1'b1;
                hz.flush_ex_o  = 1'b1;
                if (init_cnt_q == 4'(INIT_CYCLES - 1))
                    state_d = S_RUN;
                else
                    init_cnt_d = init_cnt_q + 4'd1;
            end
            S_RUN, S_HOLD: begin
                if (hz.mem_wait_i) begin
                    hz.stall_if_o  = 1'b1;
                    hz.stall_dec_o = 1'b1;
                    hz.stall_ex_o  = 1'b1;
                    hz.stall_mem_o = 1'b1;
                    hz.bubble_wb_o = 1'b1;
                end else if (hz.ex_busy_i) begin
                    hz.stall_if_o   = 1'b1;
                    hz.stall_dec_o  = 1'b1;
                    hz.stall_ex_o   = 1'b1;
                    hz.bubble_mem_o = 1'b1;
                end else if (m_exc) begin
                    hz.flush_if_o  = 1'b1;
                    hz.flush_dec_o = 1'b1;
                    hz.flush_ex_o  = 1'b1;
                end else if (m_br) begin
                    hz.flush_if_o  = 1'b1;
                    hz.flush_dec_o = 1'b1;
                end else if (hz.ddep_conflict_i) begin
                    hz.stall_if_o  = 1'b1;
                    hz.stall_dec_o = 1'b1;
                    hz.bubble_ex_o = 1'b1;
                end
                // Blocked redirects park in pend_q until the stall drops
                if (blk) begin
                    pend_d = {m_exc, m_br};
                    if (m_exc | m_br)
                        state_d = S_HOLD;
                end else begin
                    pend_d  = '0;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (hz.cnt_clr_i)
            cnt_q <= '0;
        else if (hz.stall_if_o && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign hz.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pp_hazard_ctrl.sv
// Scoreboard bench for pp_hazard_ctrl: directed scenarios
// then random traffic against a cycle-level reference model.
module tb_pp_hazard_ctrl;

    localparam int INIT_CYCLES = 2;
    localparam int CNT_W       = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pp_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pp_hazard_ctrl #(
        .INIT_CYCLES(INIT_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz.slave)
    );

    typedef struct packed {
        logic [10:0]      ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: kind 0 none, 1 branch, 2 exception
    int m_since = 0;
    bit m_run   = 0;
    int m_pend  = 0;
    int m_cnt   = 0;
    bit p_rst   = 0;
    bit p_ex    = 0;
    bit p_mem   = 0;
    bit p_clr   = 0;
    bit p_stall = 0;
    int p_kind  = 0;

    task automatic step(bit rn, bit ddep, bit ex, bit mem,
                        bit br, bit exc, bit clr);
        bit   sif, sdec, sex, smem, bex, bmem, bwb;
        bit   fif, fdec, fex, ini;
        int   kind, k;
        exp_t e;
        @(posedge clk);
        if (!p_rst) begin
            m_since = 0;
            m_run   = 0;
            m_pend  = 0;
            m_cnt   = 0;
        end else begin
            if (p_clr)
                m_cnt = 0;
            else if (p_stall && m_cnt < CMAX)
                m_cnt++;
            if (!m_run) begin
                m_since++;
                if (m_since >= INIT_CYCLES) m_run = 1;
            end else if (p_ex || p_mem) begin
                if (p_kind > m_pend) m_pend = p_kind;
            end else begin
                m_pend = 0;
            end
        end
        #1;
        rst_n              = rn;
        hz.ddep_conflict_i = ddep;
        hz.ex_busy_i       = ex;
        hz.mem_wait_i      = mem;
        hz.branch_taken_i  = br;
        hz.exc_i           = exc;
        hz.cnt_clr_i       = clr;
        {sif, sdec, sex, smem, bex, bmem, bwb} = '0;
        {fif, fdec, fex, ini} = '0;
        kind = exc ? 2 : (br ? 1 : 0);
        k    = (m_pend > kind) ? m_pend : kind;
        if (!m_run) begin
            {fif, fdec, fex, ini} = 4'b1111;
        end else if (mem) begin
            {sif, sdec, sex, smem, bwb} = 5'b11111;
        end else if (ex) begin
            {sif, sdec, sex, bmem} = 4'b1111;
        end else if (k == 2) begin
            {fif, fdec, fex} = 3'b111;
        end else if (k == 1) begin
            {fif, fdec} = 2'b11;
        end else if (ddep) begin
            {sif, sdec, bex} = 3'b111;
        end
        e.ctl = {sif, sdec, sex, smem, bex, bmem, bwb,
                 fif, fdec, fex, ini};
        e.cnt = CNT_W'(m_cnt);
        q.push_back(e);
        p_rst   = rn;
        p_ex    = ex;
        p_mem   = mem;
        p_clr   = clr;
        p_stall = sif;
        p_kind  = kind;
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a.ctl = {hz.stall_if_o, hz.stall_dec_o,
                         hz.stall_ex_o, hz.stall_mem_o,
                         hz.bubble_ex_o, hz.bubble_mem_o,
                         hz.bubble_wb_o, hz.flush_if_o,
                         hz.flush_dec_o, hz.flush_ex_o,
                         hz.init_o};
                a.cnt = hz.stall_cnt_o;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                             vectors, a.ctl, a.cnt, e.ctl, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        hz.ddep_conflict_i = 1'b0;
        hz.ex_busy_i       = 1'b0;
        hz.mem_wait_i      = 1'b0;
        hz.branch_taken_i  = 1'b0;
        hz.exc_i           = 1'b0;
        hz.cnt_clr_i       = 1'b0;
        // args: rst_n ddep ex mem br exc clr
        repeat (2) step(0, 1, 0, 0, 0, 0, 0);
        repeat (5) step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0);
        step(1, 0, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        repeat (20) step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 1);
        repeat (3) step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0);
        repeat (5) step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99, 0) >= 2,
                 $urandom_range(99, 0) < 40,
                 $urandom_range(99, 0) < 20,
                 $urandom_range(99, 0) < 20,
                 $urandom_range(99, 0) < 15,
                 $urandom_range(99, 0) < 7,
                 $urandom_range(99, 0) < 5);
        end
        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked, want 0",
                     q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
